// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants: datapath width, register index width,
//               register count and the hard-wired zero register index.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Index of the architectural zero register ($0)
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux
// Description : Write-back data select (load data vs ALU result). Pure
//               combinational mux; also instantiated by EX forwarding.
// Ports       : i_sel        1 = select i_mem_data, 0 = select i_alu_result
//               i_mem_data   load data
//               i_alu_result ALU result
//               o_wb_data    selected write-back data
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_wb_data
);

    assign o_wb_data = i_sel ? i_mem_data : i_alu_result;

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MEM/WB write-back stage plus the architectural register file.
//               Selects write-back data, commits it on posedge, serves two
//               asynchronous ID read ports with optional same-cycle bypass,
//               exports the committed write for EX forwarding and counts
//               retired (effective) writes.
// Ports       : clk_i, rst_i (async, active-low)
//               RegWrite_i, MemtoReg_i, MemData_i, ALU_result_i, RDdata_i
//                                  MEM/WB inputs
//               RSaddr_i, RTaddr_i  ID read indices
//               RSdata_o, RTdata_o  read data (combinational)
//               WBdata_o            selected write-back data
//               WBwrite_o           effective write (RegWrite && rd != $0)
//               WBaddr_o            destination index
//               wb_count_o          effective writes since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] MemData_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [ADDR_W-1:0] RDdata_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              WBwrite_o,
    output logic [ADDR_W-1:0] WBaddr_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    import cpu_pkg::*;

    localparam int                c_NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO     = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [CNT_W-1:0]  r_wb_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_eff;
    logic              w_byp_en;

    wb_mux #(
        .DATA_W       (DATA_W)
    ) u_wb_mux (
        .i_sel        (MemtoReg_i),
        .i_mem_data   (MemData_i),
        .i_alu_result (ALU_result_i),
        .o_wb_data    (w_wb_data)
    );

    assign w_eff = RegWrite_i && (RDdata_i != c_ZERO);

    // Bypass is suppressed while reset is held so reads stay at zero even
    // if MEM/WB presents a write during reset.
    assign w_byp_en = BYPASS && w_eff && rst_i;

    // Entry 0 is cleared by reset and never written afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_eff) begin
            r_regs[RDdata_i] <= w_wb_data;
            r_wb_count       <= r_wb_count + CNT_W'(1);
        end
    end

    // One read path, instantiated twice below. All inputs are arguments so
    // each continuous assignment is sensitive to everything it depends on.
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              byp_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] v;
        if (addr == c_ZERO) begin
            v = '0;
        end else if (byp_en && (addr == wr_addr)) begin
            v = wr_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    assign RSdata_o = f_read(RSaddr_i, r_regs[RSaddr_i], w_byp_en, RDdata_i, w_wb_data);
    assign RTdata_o = f_read(RTaddr_i, r_regs[RTaddr_i], w_byp_en, RDdata_i, w_wb_data);

    assign WBdata_o   = w_wb_data;
    assign WBwrite_o  = w_eff;
    assign WBaddr_o   = RDdata_i;
    assign wb_count_o = r_wb_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed self-checking bench for wb_regfile. Two instances
//               share stimulus: dut (defaults, bypass on) and dut_b
//               (4-bit counter, bypass off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;

    logic [31:0] rs_data,  rt_data,  wb_data;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_count;

    logic [31:0] rs_data_b, rt_data_b, wb_data_b;
    logic        wb_write_b;
    logic [4:0]  wb_addr_b;
    logic [3:0]  wb_count_b;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .RegWrite_i   (reg_write),
        .MemtoReg_i   (mem_to_reg),
        .MemData_i    (mem_data),
        .ALU_result_i (alu_result),
        .RDdata_i     (rd),
        .RSaddr_i     (rs_addr),
        .RTaddr_i     (rt_addr),
        .RSdata_o     (rs_data),
        .RTdata_o     (rt_data),
        .WBdata_o     (wb_data),
        .WBwrite_o    (wb_write),
        .WBaddr_o     (wb_addr),
        .wb_count_o   (wb_count)
    );

    wb_regfile #(
        .CNT_W  (4),
        .BYPASS (1'b0)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .RegWrite_i   (reg_write),
        .MemtoReg_i   (mem_to_reg),
        .MemData_i    (mem_data),
        .ALU_result_i (alu_result),
        .RDdata_i     (rd),
        .RSaddr_i     (rs_addr),
        .RTaddr_i     (rt_addr),
        .RSdata_o     (rs_data_b),
        .RTdata_o     (rt_data_b),
        .WBdata_o     (wb_data_b),
        .WBwrite_o    (wb_write_b),
        .WBaddr_o     (wb_addr_b),
        .wb_count_o   (wb_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_data   = '0;
        alu_result = '0;
        rd         = '0;
        rs_addr    = '0;
        rt_addr    = '0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Pre-load reg7 so the reset check has something to clear
        reg_write = 1'b1; alu_result = 32'h55; rd = 5'd7;
        tick();
        reg_write = 1'b0; rs_addr = 5'd7;
        #1;
        chk("preload_rd", rs_data, 32'h55);
        chk("preload_cnt", wb_count, 32'd1);

        // 1: asynchronous reset mid-cycle, with a write presented meanwhile
        #2;
        rst_n = 1'b0;
        reg_write = 1'b1; alu_result = 32'h99; rd = 5'd7;
        #1;
        chk("rst_cnt", wb_count, 32'd0);
        chk("rst_cnt_b", {28'd0, wb_count_b}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            chk("rst_rs", rs_data, 32'd0);
            chk("rst_rt", rt_data, 32'd0);
        end
        reg_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2: ALU write to reg5
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h0000_1234; rd = 5'd5;
        tick();
        reg_write = 1'b0; rs_addr = 5'd5;
        #1;
        chk("alu_rs", rs_data, 32'h0000_1234);
        chk("alu_cnt", wb_count, 32'd1);

        // 3: load write with same-cycle read of the destination on both ports
        reg_write = 1'b1; mem_to_reg = 1'b1; mem_data = 32'hDEAD_BEEF; rd = 5'd9;
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        chk("byp_rs", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", rt_data, 32'hDEAD_BEEF);
        chk("nobyp_rs", rs_data_b, 32'd0);
        chk("nobyp_rt", rt_data_b, 32'd0);
        chk("wb_data", wb_data, 32'hDEAD_BEEF);
        chk("wb_write", {31'd0, wb_write}, 32'd1);
        chk("wb_addr", {27'd0, wb_addr}, 32'd9);
        tick();
        reg_write = 1'b0;
        #1;
        chk("load_rs_b", rs_data_b, 32'hDEAD_BEEF);
        chk("load_cnt", wb_count, 32'd2);

        // Independent ports, no write
        rs_addr = 5'd5; rt_addr = 5'd9;
        #1;
        chk("two_rs", rs_data, 32'h0000_1234);
        chk("two_rt", rt_data, 32'hDEAD_BEEF);

        // 4: $0 guard
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hFFFF_FFFF; rd = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        chk("z_wbwrite", {31'd0, wb_write}, 32'd0);
        chk("z_wbdata", wb_data, 32'hFFFF_FFFF);
        chk("z_rs", rs_data, 32'd0);
        chk("z_rt", rt_data, 32'd0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("z_rs_after", rs_data, 32'd0);
        chk("z_cnt", wb_count, 32'd2);

        // 6: write to reg3 at an edge while reset is held
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hAA; rd = 5'd3;
        rs_addr = 5'd3; rt_addr = 5'd3;
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("ovl_rs", rs_data, 32'd0);
        chk("ovl_cnt", wb_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_byp", rs_data, 32'hAA);
        chk("rel_nobyp", rs_data_b, 32'd0);
        tick();
        reg_write = 1'b0;
        #1;
        chk("rel_rs", rs_data, 32'hAA);
        chk("rel_cnt", wb_count, 32'd1);

        // Bubble with X on data/select must not disturb reg3
        rd = 5'd3; alu_result = 32'd7; mem_to_reg = 1'bx; mem_data = 'x;
        #1;
        chk("bub_rs_comb", rs_data, 32'hAA);
        tick();
        chk("bub_rs", rs_data, 32'hAA);
        chk("bub_rt_b", rt_data_b, 32'hAA);
        chk("bub_cnt", wb_count, 32'd1);

        // 5: counter wrap on the 4-bit instance
        mem_to_reg = 1'b0; mem_data = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            reg_write = 1'b1; rd = 5'(i + 1); alu_result = 32'(i * 3 + 1);
            tick();
            if (i == 14) chk("wrap_15", {28'd0, wb_count_b}, 32'd15);
            if (i == 15) chk("wrap_16", {28'd0, wb_count_b}, 32'd0);
        end
        reg_write = 1'b0;
        rs_addr = 5'd17; rt_addr = 5'd1;
        #1;
        chk("wrap_17", {28'd0, wb_count_b}, 32'd1);
        chk("cnt_17", wb_count, 32'd17);
        chk("wrap_rs", rs_data, 32'd49);
        chk("wrap_rt", rt_data, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
